// File: rtl/if_id_queue_pkg.sv
// if_id_queue shared definitions
// bus widths and bubble constants for the fetch queue
package if_id_queue_pkg;
  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [31:0] ZERO_WORD       = 32'h0;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0;
endpackage

// File: rtl/if_id_queue_storage.sv
// if_id_queue entry array
// one write port, one asynchronous read port, no reset
module if_id_queue_storage
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ADDR_BUS + DATA_BUS,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             write_enable,
  input  logic [PW-1:0]    write_pointer,
  input  logic [WIDTH-1:0] write_data,
  input  logic [PW-1:0]    read_pointer,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // capture the offered entry at the write slot
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_pointer] <= write_data;
    end
  end

  assign read_data = mem[read_pointer];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID decoupling queue
// valid/ready on both sides, flush on redirect
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int DATA_WIDTH = DATA_BUS,
  parameter int DEPTH      = 2,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [ADDR_WIDTH-1:0]  if_program_counter,
  input  logic [DATA_WIDTH-1:0]  if_instruction,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [ADDR_WIDTH-1:0]  id_program_counter,
  output logic [DATA_WIDTH-1:0]  id_instruction,
  output logic [COUNT_WIDTH-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] FULL =
    COUNT_WIDTH'(DEPTH);

  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          head;

  assign if_ready = (count != FULL) ? ENABLE : DISABLE;
  assign id_valid = (count != '0) ? ENABLE : DISABLE;
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  if_id_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_storage (
    .clock         (clock),
    .write_enable  (push & ~flush),
    .write_pointer (wr_ptr),
    .write_data    ({if_program_counter, if_instruction}),
    .read_pointer  (rd_ptr),
    .read_data     (head)
  );

  // pointers and count; flush overrides any push or pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push && !pop: count <= count + COUNT_WIDTH'(1);
        pop && !push: count <= count - COUNT_WIDTH'(1);
        default:      count <= count;
      endcase
    end
  end

  assign id_program_counter = id_valid
    ? head[EW-1 -: ADDR_WIDTH]
    : ADDR_WIDTH'(ZERO_WORD);
  assign id_instruction = id_valid
    ? head[DATA_WIDTH-1:0]
    : DATA_WIDTH'(NOP_INSTRUCTION);
  assign occupancy = count;

endmodule
